// File: rtl/dmem_ctrl.sv
// Data-memory controller: sequences single core read/write requests onto a
// synchronous single-port SRAM with WAIT_STATES wait cycles; one response
// pulse per accepted request. Optional range checking via DMEM_RANGE_CHECK_EN.
module dmem_ctrl #(
  parameter int XLEN        = 32,
  parameter int AW          = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [XLEN-1:0] data_adr,
  input  logic [XLEN-1:0] data_o,
  input  logic [3:0]      strobe,
  output logic [XLEN-1:0] dmem_resp,
  output logic            dmem_resp_v,
  output logic            sram_en,
  output logic [3:0]      sram_we,
  output logic [AW-1:0]   sram_adr,
  output logic [XLEN-1:0] sram_wdata,
  input  logic [XLEN-1:0] sram_rdata
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic            dmem_err
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic            bad_q, bad_d;
  logic [XLEN-1:0] resp_q, resp_d;
  logic            resp_v_q, resp_v_d;
  logic            en_q, en_d;
  logic [3:0]      we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            err_q, err_d;
  logic            oob;

`ifdef DMEM_RANGE_CHECK_EN
  assign oob      = |data_adr[XLEN-1:AW+2];
  assign dmem_err = err_q;
  logic unused_ok;
  assign unused_ok = ^data_adr[1:0];
`else
  // Without range checking the upper address bits simply wrap.
  assign oob = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{data_adr[XLEN-1:AW+2], data_adr[1:0], err_q};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    bad_d    = bad_q;
    resp_d   = resp_q;
    resp_v_d = 1'b0;
    en_d     = 1'b0;
    we_d     = 4'h0;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: if (w_v || r_v) begin
        // Write wins on a simultaneous request; the read is re-issued by the core.
        state_d = ACCESS;
        wr_d    = w_v;
        bad_d   = oob;
        en_d    = !oob;
        we_d    = (w_v && !oob) ? strobe : 4'h0;
        adr_d   = data_adr[AW+1:2];
        wdata_d = data_o;
      end
      ACCESS: begin
        state_d = WAIT;
        cnt_d   = 4'(WAIT_STATES);
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d  = RESP;
          resp_v_d = 1'b1;
          err_d    = bad_q;
          resp_d   = (wr_q || bad_q) ? '0 : sram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      bad_q    <= 1'b0;
      resp_q   <= '0;
      resp_v_q <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 4'h0;
      adr_q    <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      bad_q    <= bad_d;
      resp_q   <= resp_d;
      resp_v_q <= resp_v_d;
      en_q     <= en_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  assign dmem_resp   = resp_q;
  assign dmem_resp_v = resp_v_q;
  assign sram_en     = en_q;
  assign sram_we     = we_q;
  assign sram_adr    = adr_q;
  assign sram_wdata  = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: behavioural SRAM, vector table,
// response scoreboard and hand-written multi-cycle sequences.
module tb_dmem_ctrl;
  localparam int XLEN = 32;
  localparam int AW   = 12;
  localparam int WS   = 1;

  logic            clk = 1'b0;
  logic            rst, r_v, w_v;
  logic [XLEN-1:0] data_adr, data_o, dmem_resp, sram_wdata, sram_rdata;
  logic [3:0]      strobe, sram_we;
  logic            dmem_resp_v, sram_en;
  logic [AW-1:0]   sram_adr;
`ifdef DMEM_RANGE_CHECK_EN
  logic            dmem_err;
`endif

  dmem_ctrl #(.XLEN(XLEN), .AW(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .r_v(r_v), .w_v(w_v), .data_adr(data_adr),
    .data_o(data_o), .strobe(strobe), .dmem_resp(dmem_resp),
    .dmem_resp_v(dmem_resp_v), .sram_en(sram_en), .sram_we(sram_we),
    .sram_adr(sram_adr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef DMEM_RANGE_CHECK_EN
    , .dmem_err(dmem_err)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural synchronous SRAM: read data appears the cycle after sram_en.
  logic [XLEN-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 4'h0) sram_rdata <= mem[sram_adr];
      else for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_adr][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end

  int n_chk = 0, n_pass = 0;
  int en_cnt = 0, we_cnt = 0, resp_cnt = 0, cyc = 0;
  logic [31:0] q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard side: every response pops one expected word.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (sram_en) en_cnt++;
    if (|sram_we) we_cnt++;
    if (dmem_resp_v) begin
      resp_cnt++;
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_resp: got resp 0x%08h with nothing outstanding", dmem_resp);
      end else begin
        e = q.pop_front();
        chk("resp", dmem_resp, e);
      end
    end
  end

  task automatic wait_resp(input string nm, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dmem_resp_v) begin at = cyc; break; end
    end
    if (at < 0) begin
      n_chk++;
      $display("FAIL %s.timeout: got no response expected one within 20 cycles", nm);
    end
  endtask

  // One request held until its response; checks access cycle and latency.
  task automatic txn(input bit w, input bit both, input logic [31:0] adr,
                     input logic [31:0] d, input logic [3:0] st, input logic [31:0] exp,
                     input bit exp_en, input bit exp_err, input string nm);
    int lat;
    w_v = w; r_v = !w || both; data_adr = adr; data_o = d; strobe = st;
    q.push_back(exp);
    @(posedge clk);
    lat = 21;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({nm, ".sram_en"}, 32'(sram_en), 32'(exp_en));
        chk({nm, ".sram_we"}, 32'(sram_we), (w && exp_en) ? 32'(st) : 32'h0);
        if (exp_en) chk({nm, ".sram_adr"}, 32'(sram_adr), 32'(adr[AW+1:2]));
      end
      if (dmem_resp_v) begin lat = i; break; end
      @(posedge clk);
    end
    chk({nm, ".latency"}, 32'(lat), 32'(WS + 2));
`ifdef DMEM_RANGE_CHECK_EN
    chk({nm, ".err"}, 32'(dmem_err), 32'(exp_err));
`else
    if (exp_err) chk({nm, ".err_unexpected_cfg"}, 32'(dmem_resp_v), 32'h1);
`endif
    @(posedge clk); #1;
    w_v = 1'b0; r_v = 1'b0;
  endtask

  typedef struct {
    bit          w;
    logic [31:0] adr;
    logic [31:0] d;
    logic [3:0]  st;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[12];

  initial begin
    int t1, t2, rc0, en0, we0;
    tv[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0};
    tv[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF};
    tv[2]  = '{1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0};
    tv[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA};
    tv[4]  = '{1'b1, 32'h0,    32'h12345678, 4'hF, 32'h0};
    tv[5]  = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678};
    tv[6]  = '{1'b1, 32'h3FFC, 32'hCAFEF00D, 4'hF, 32'h0};
    tv[7]  = '{1'b0, 32'h3FFC, 32'h0,        4'h0, 32'hCAFEF00D};
    tv[8]  = '{1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0};
    tv[9]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'hDEADBEAA};
    tv[10] = '{1'b1, 32'h20,   32'hA5A5FFFF, 4'hC, 32'h0};
    tv[11] = '{1'b0, 32'h20,   32'h0,        4'h0, 32'hA5A50000};

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    sram_rdata = '0;
    rst = 1'b1; r_v = 1'b0; w_v = 1'b0; data_adr = '0; data_o = '0; strobe = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst.resp_v", 32'(dmem_resp_v), 32'h0);
    chk("rst.resp", dmem_resp, 32'h0);
    chk("rst.sram_we", 32'(sram_we), 32'h0);
    chk("rst.sram_adr", 32'(sram_adr), 32'h0);
    chk("rst.sram_wdata", sram_wdata, 32'h0);
    chk("rst.en_never", 32'(en_cnt), 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++)
      txn(tv[i].w, 1'b0, tv[i].adr, tv[i].d, tv[i].st, tv[i].exp, 1'b1, 1'b0, $sformatf("vec%0d", i));

    // Simultaneous read and write: only the write runs.
    en0 = en_cnt; we0 = we_cnt;
    txn(1'b1, 1'b1, 32'h40, 32'h11223344, 4'hF, 32'h0, 1'b1, 1'b0, "both");
    chk("both.accesses", 32'(en_cnt - en0), 32'h1);
    chk("both.writes", 32'(we_cnt - we0), 32'h1);
    txn(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h11223344, 1'b1, 1'b0, "both.rd");

    // Read held through RESP is accepted again in the following IDLE cycle.
    r_v = 1'b1; data_adr = 32'h10;
    q.push_back(32'hDEADBEAA); q.push_back(32'hDEADBEAA);
    wait_resp("hold1", t1);
    wait_resp("hold2", t2);
    chk("hold.gap", 32'(t2 - t1), 32'(WS + 3));
    @(posedge clk); #1 r_v = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset during WAIT discards the request without a response.
    rc0 = resp_cnt;
    r_v = 1'b1; data_adr = 32'h10;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1; r_v = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw.resp_v", 32'(dmem_resp_v), 32'h0);
    chk("rstw.resp", dmem_resp, 32'h0);
    chk("rstw.sram_en", 32'(sram_en), 32'h0);
    repeat (5) @(posedge clk);
    chk("rstw.no_resp", 32'(resp_cnt - rc0), 32'h0);
    #1;
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 1'b1, 1'b0, "after_rst");

    // Address above the SRAM range.
`ifdef DMEM_RANGE_CHECK_EN
    en0 = en_cnt;
    txn(1'b0, 1'b0, 32'h4000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, "oob");
    chk("oob.no_access", 32'(en_cnt - en0), 32'h0);
`else
    txn(1'b0, 1'b0, 32'h4000, 32'h0, 4'h0, 32'h12345678, 1'b1, 1'b0, "wrap");
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
